mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control FSM for the MIPS core. It replaces the single-cycle main decoder when the datapath is shared across cycles (one memory, one ALU) and sequences each instruction through fetch, decode, execute, memory and writeback. It sits between the instruction register (opcode field) and the multicycle datapath muxes and write enables. ALU function decode stays in the existing ALU decoder, which is driven by `ALUOp`.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Op` input 6: opcode from the instruction register, sampled in DECODE.
- `mem_ready` input 1: memory access complete; used only with `MC_MEM_WAIT_EN`.
- `IorD` output 1: memory address select, 0=PC, 1=ALUOut.
- `MemWrite` output 1: memory write enable.
- `IRWrite` output 1: instruction register load.
- `PCWrite` output 1: unconditional PC load.
- `Branch` output 1: conditional PC load, ANDed with Zero in the datapath.
- `RegDst` output 1: destination register select, 1=rd, 0=rt.
- `MemtoReg` output 1: writeback select, 1=data register.
- `RegWrite` output 1: register file write enable.
- `ALUSrcA` output 1: ALU A select, 0=PC, 1=A register.
- `ALUSrcB` output 2: ALU B select, 00=B, 01=4, 10=SignImm, 11=SignImm<<2.
- `ALUOp` output 2: 00=add, 01=sub, 10=funct.
- `PCSrc` output 2: PC source, 00=ALUResult, 01=ALUOut, 10=jump target.
- `instr_done` output 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op` output 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` output 4: current state, for debug.

## Operation
- Moore FSM with these states: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Any output not listed for a state is 0.
- Reset puts the FSM in IDLE with all outputs 0. IDLE goes to FETCH unconditionally on the next edge.
- **FETCH:** IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=ack. Goes to DECODE on ack.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by `Op`:
  - lw/sw (100011/101011) → MEMADR
  - R-type (000000) → EXEC
  - beq (000100) → BRANCH
  - addi (001000) → ADDIEX
  - j (000010) → JUMP
  - any other opcode → FETCH, with `illegal_op`=1 this cycle.
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if lw, MEMWR if sw. `Op` is re-read here; the IR is stable.
- **MEMRD:** IorD=1. Goes to MEMWB on ack.
- **MEMWB:** RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Goes to FETCH.
- **MEMWR:** IorD=1, MemWrite=1 (held until ack), instr_done=ack. Goes to FETCH on ack.
- **EXEC:** ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- **ALUWB:** RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, instr_done=1. Goes to FETCH.
- **ADDIEX:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- **ADDIWB:** RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
- **JUMP:** PCSrc=10, PCWrite=1, instr_done=1. Goes to FETCH.
- **Definition of "ack":** equals `mem_ready` when `MC_MEM_WAIT_EN` is defined, constant 1 otherwise. Only FETCH, MEMRD and MEMWR depend on ack.
- **Unreachable state encodings:** go to IDLE with all outputs 0.

## Timing
- **Cycle counts with no wait:** lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2 (FETCH, DECODE).
- **Each stall cycle** (ack=0 in FETCH/MEMRD/MEMWR) adds exactly one cycle. During a stall:
  - the state holds;
  - outputs hold, except IRWrite/PCWrite stay 0 in FETCH;
  - MemWrite stays 1 in MEMWR;
  - instr_done stays 0.
- **Output timing:** all outputs except ack-qualified enables are pure functions of the registered state, so they are valid on the same cycle as the state with no added latency.
- **Reset mid-instruction:** asserting `rst_n`=0 immediately (asynchronously) forces IDLE and zeroes all outputs, including a MemWrite in progress. After release, the first FETCH occurs on the second rising edge.
- **Pulse width:** `instr_done` and `illegal_op` are never high together, and each is exactly one cycle wide.

## Configuration
- `MC_MEM_WAIT_EN` defined: FETCH, MEMRD and MEMWR wait for `mem_ready`=1, so variable-latency memory is supported.
- `MC_MEM_WAIT_EN` undefined: `mem_ready` is ignored (port kept, unused), and every state lasts exactly one cycle.

## Structure
- Package `mips_pkg` holds:
  - the state enum (4-bit encoding, IDLE=0);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALUOp constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - ALUSrcB and PCSrc select constants.
- Split into two parts:
  - the state register plus next-state logic, in `mc_controller`;
  - one sub-module `mc_out_decode`, a combinational state/ack → control-word mapping.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs 0, state=IDLE. After release, FETCH on the 2nd edge with IRWrite=PCWrite=1.
- **Instruction sequence, no stalls:** lw, sw, R-type, beq, addi, j → state sequences and cycle counts 5/4/4/3/4/3. Exactly one instr_done per instruction, with control words matching the Operation section per state.
- **Wait-enabled build:** `mem_ready`=0 for 3 cycles in FETCH and in MEMWR of an sw → each holds 3 extra cycles. MemWrite stays 1 throughout MEMWR, IRWrite stays 0 until ready, instr_done fires on the ready cycle.
- **Illegal opcode:** `Op`=6'b111111 → illegal_op pulses in DECODE, next state FETCH, no RegWrite/MemWrite/PCWrite after the fetch.
- **Reset during MEMWR:** `rst_n` dropped mid-cycle → MemWrite falls without waiting for the clock, state=IDLE.
- **Wait-disabled build:** `mem_ready` tied 0 → lw still completes in 5 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared types and constants for the multicycle MIPS controller.
//           Contains the FSM state enum (4-bit, IDLE=0), opcode constants,
//           ALUOp / ALUSrcB / PCSrc select constants, the packed control word
//           and a helper that classifies supported opcodes.
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12
    } mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    // Datapath control word produced by the output decoder.
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_out_decode.sv
`default_nettype none
// ============================================================================
// Module  : mc_out_decode
// Purpose : Combinational mapping from the controller state (plus the memory
//           acknowledge) to the datapath control word. Pure Moore decode
//           except for the ack-qualified enables in FETCH and MEMWR.
// Ports   : state [3:0] in  - registered FSM state
//           ack         in  - memory handshake complete this cycle
//           ctrl        out - control word (ctrl_t)
// Revision: 1.0 - initial release
// ============================================================================
module mc_out_decode
    import mips_pkg::*;
(
    input  logic [3:0] state,
    input  logic       ack,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALURESULT;
                // Load IR and PC+4 only on the cycle the instruction word arrives.
                ctrl.ir_write  = ack;
                ctrl.pc_write  = ack;
            end
            DECODE: begin
                // Branch target precompute: PC + (SignImm << 2).
                ctrl.alu_src_b = ALUSRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                // Write strobe is held for the whole access; completion only on ack.
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = ack;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = ALUSRCB_B;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module  : mc_controller
// Purpose : Multicycle MIPS control FSM. Sequences each instruction through
//           fetch / decode / execute / memory / writeback and drives the
//           shared-datapath muxes and write enables.
// Config  : MC_MEM_WAIT_EN - when defined, FETCH, MEMRD and MEMWR stall until
//           mem_ready=1; when undefined mem_ready is ignored.
// Ports   : clk, rst_n (async active-low), Op[5:0], mem_ready
//           IorD, MemWrite, IRWrite, PCWrite, Branch, RegDst, MemtoReg,
//           RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0],
//           instr_done, illegal_op, state[3:0] (debug)
// Revision: 1.0 - initial release
// ============================================================================
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    mc_state_t state_q;
    mc_state_t state_d;
    logic      ack;
    ctrl_t     ctrl;

`ifdef MC_MEM_WAIT_EN
    assign ack = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ack              = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  state_d = ack ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            // IR still holds the lw/sw word, so Op can be re-examined here.
            MEMADR: state_d = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = ack ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = ack ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            JUMP:   state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    mc_out_decode u_out_decode (
        .state (state_q),
        .ack   (ack),
        .ctrl  (ctrl)
    );

    assign IorD       = ctrl.iord;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign PCWrite    = ctrl.pc_write;
    assign Branch     = ctrl.branch;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegWrite   = ctrl.reg_write;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign PCSrc      = ctrl.pc_src;
    assign instr_done = ctrl.instr_done;
    assign illegal_op = (state_q == DECODE) && !op_is_legal(Op);
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_mc_controller
// Purpose : Scoreboard bench for mc_controller. Stimulus expands each
//           instruction into its phase list and pushes the expected control
//           word for every cycle; a monitor pops and compares each cycle and
//           checks instruction lengths at every completion pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mc_controller;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, PCWrite, Branch, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    mc_controller dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord, memwrite, irwrite, pcwrite, branch, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, aluop, pcsrc;
        logic       done, illegal;
        logic [3:0] st;
    } obs_t;

    obs_t expq[$];
    int   lenq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    int   mon_cnt = 0;
    int   mon_cyc = 0;
    obs_t mon_act, mon_exp;
    int   exp_len;

`ifdef MC_MEM_WAIT_EN
    localparam bit WAIT_BUILD = 1'b1;
`else
    localparam bit WAIT_BUILD = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    function automatic obs_t actual();
        obs_t a;
        a = '{IorD, MemWrite, IRWrite, PCWrite, Branch, RegDst, MemtoReg, RegWrite, ALUSrcA,
              ALUSrcB, ALUOp, PCSrc, instr_done, illegal_op, state};
        return a;
    endfunction

    // Expected outputs for one cycle spent in phase p, written from the
    // per-state output table.
    function automatic obs_t exp_word(input mc_state_t p, input logic ack, input logic [5:0] op);
        obs_t w;
        w    = '0;
        w.st = p;
        case (p)
            FETCH:  begin w.alusrcb = 2'b01; w.irwrite = ack; w.pcwrite = ack; end
            DECODE: begin w.alusrcb = 2'b11; w.illegal = !legal(op); end
            MEMADR: begin w.alusrca = 1'b1; w.alusrcb = 2'b10; end
            MEMRD:  begin w.iord = 1'b1; end
            MEMWB:  begin w.memtoreg = 1'b1; w.regwrite = 1'b1; w.done = 1'b1; end
            MEMWR:  begin w.iord = 1'b1; w.memwrite = 1'b1; w.done = ack; end
            EXEC:   begin w.alusrca = 1'b1; w.aluop = 2'b10; end
            ALUWB:  begin w.regdst = 1'b1; w.regwrite = 1'b1; w.done = 1'b1; end
            BRANCH: begin w.alusrca = 1'b1; w.aluop = 2'b01; w.pcsrc = 2'b01; w.branch = 1'b1; w.done = 1'b1; end
            ADDIEX: begin w.alusrca = 1'b1; w.alusrcb = 2'b10; end
            ADDIWB: begin w.regwrite = 1'b1; w.done = 1'b1; end
            JUMP:   begin w.pcsrc = 2'b10; w.pcwrite = 1'b1; w.done = 1'b1; end
            default: w = '0;
        endcase
        return w;
    endfunction

    // mode 0: random ready, 1: ready low 3 cycles in FETCH/MEMWR,
    // 2: ready tied low, 3: ready always high. Stalls bounded to 3 cycles.
    task automatic run_instr(input logic [5:0] op, input int mode);
        mc_state_t ph[$];
        int        n = 0;
        ph.push_back(FETCH);
        ph.push_back(DECODE);
        case (op)
            6'b100011: begin ph.push_back(MEMADR); ph.push_back(MEMRD); ph.push_back(MEMWB); end
            6'b101011: begin ph.push_back(MEMADR); ph.push_back(MEMWR); end
            6'b000000: begin ph.push_back(EXEC); ph.push_back(ALUWB); end
            6'b000100: ph.push_back(BRANCH);
            6'b001000: begin ph.push_back(ADDIEX); ph.push_back(ADDIWB); end
            6'b000010: ph.push_back(JUMP);
            default: ;
        endcase
        foreach (ph[k]) begin
            bit waits = (ph[k] == FETCH) || (ph[k] == MEMRD) || (ph[k] == MEMWR);
            int zeros = 0;
            logic r, ack;
            do begin
                @(posedge clk);
                #1;
                if (k == 0) Op = op;
                case (mode)
                    0: r = ($urandom_range(0, 3) != 0);
                    1: r = !((ph[k] == FETCH || ph[k] == MEMWR) && waits);
                    2: r = 1'b0;
                    default: r = 1'b1;
                endcase
                if (zeros >= 3) r = 1'b1;
                if (mode == 1 && zeros < 3 && (ph[k] == FETCH || ph[k] == MEMWR)) r = 1'b0;
                mem_ready = r;
                ack = WAIT_BUILD ? r : 1'b1;
                if (!ack) zeros++;
                expq.push_back(exp_word(ph[k], ack, op));
                n++;
            end while (waits && !ack);
        end
        lenq.push_back(n);
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] o;
        case ($urandom_range(0, 6))
            0: o = 6'b100011;
            1: o = 6'b101011;
            2: o = 6'b000000;
            3: o = 6'b000100;
            4: o = 6'b001000;
            5: o = 6'b000010;
            default: begin
                o = 6'($urandom_range(0, 63));
                while (legal(o)) o = 6'($urandom_range(0, 63));
            end
        endcase
        return o;
    endfunction

    // Monitor: one expected word per cycle, plus instruction length at each
    // completion (instr_done or illegal_op).
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon_cyc++;
            mon_act = actual();
            if (expq.size() == 0) begin
                check("expq_underflow", 32'd1, 32'd0);
            end else begin
                mon_exp = expq.pop_front();
                check($sformatf("ctrl_word cyc%0d", mon_cyc), 32'(mon_act), 32'(mon_exp));
                if (mon_exp.st == 4'd0) mon_cnt = 0;
                else mon_cnt++;
            end
            if (mon_act.done || mon_act.illegal) begin
                if (lenq.size() == 0) begin
                    check("unexpected_end", 32'd1, 32'd0);
                end else begin
                    exp_len = lenq.pop_front();
                    check("instr_cycles", 32'(mon_cnt), 32'(exp_len));
                end
                mon_cnt = 0;
            end
        end
    end

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        expq.push_back(exp_word(IDLE, 1'b1, 6'd0));
        mon_en    = 1'b1;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("expq_empty", 32'(expq.size()), 32'd0);
        check("lenq_empty", 32'(lenq.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        Op        = 6'd0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_outputs", 32'(actual()), 32'd0);
        end
        release_reset();

        // Directed sequence without stalls: lw, sw, R, beq, addi, j.
        run_instr(6'b100011, 3);
        run_instr(6'b101011, 3);
        run_instr(6'b000000, 3);
        run_instr(6'b000100, 3);
        run_instr(6'b001000, 3);
        run_instr(6'b000010, 3);
        // Illegal opcode followed by a normal instruction.
        run_instr(6'b111111, 3);
        run_instr(6'b000000, 3);
        // Stall pattern in FETCH and MEMWR, then ready tied low.
        run_instr(6'b101011, 1);
        run_instr(6'b100011, 2);
        run_instr(6'b000100, 3);
        for (int i = 0; i < 60; i++) run_instr(rand_op(), 0);
        drain();

        // Reset in the middle of a store: current cycle is FETCH.
        Op        = 6'b101011;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("memwr_state", 32'(state), 32'(MEMWR));
        check("memwr_active", 32'(MemWrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_memwrite_drop", 32'(MemWrite), 32'd0);
        check("async_state_idle", 32'(state), 32'd0);
        check("async_outputs_zero", 32'(actual()), 32'd0);
        release_reset();
        for (int i = 0; i < 15; i++) run_instr(rand_op(), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
